// File: rtl/dadda_final_cpa.sv
// Final carry-propagate adder for the Dadda multiplier: prod/cout = row_a + row_b + cin.
// Latency STAGES (= WIDTH/SEG) cycles. One result per cycle when unstalled.
// Backpressure: a stall ripples combinationally from out_ready to in_ready, and bubbles are collapsed.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake for row_a, row_b, cin
//   row_a, row_b, cin   reduced sum row, aligned carry row, carry into bit 0
//   out_valid/out_ready output handshake for prod, cout
//   prod, cout          low WIDTH bits of the sum and the carry out of bit WIDTH-1
//   prod_zero           (only with DADDA_FINAL_CPA_ZERO_FLAG_EN) 1 iff prod==0 and cout==0
//
// Optional feature macro: DADDA_FINAL_CPA_ZERO_FLAG_EN.
module dadda_final_cpa #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] row_a,
  input  logic [WIDTH-1:0] row_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod,
  output logic             cout
`ifdef DADDA_FINAL_CPA_ZERO_FLAG_EN
  ,
  output logic             prod_zero
`endif
);

  localparam int STAGES = WIDTH / SEG;

  if ((SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_bad_width
    $error("dadda_final_cpa: WIDTH must be a positive multiple of SEG");
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] ld;       // stage k captures its upstream this cycle
  logic [STAGES-1:0] src_vld;  // valid bit presented to stage k

  // Stage k is blocked only when it and every stage downstream of it are full
  // and the consumer is not taking the head result.
  always_comb begin
    logic blocked;
    blocked = ~out_ready;
    ld      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      blocked = blocked & vld_q[k];
      ld[k]   = ~blocked;
    end
  end

  always_comb begin
    src_vld    = '0;
    src_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
    end
  end

  // A loading stage takes whatever is upstream, bubble or not.
  assign vld_d = (ld & src_vld) | (~ld & vld_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[STAGES-1];

  // ---------------------------------------------------------------------------
  // Datapath. x_q holds {finished sum segments, remaining row_a bits} rotated so
  // that the next row_a segment always sits at the bottom; after the last stage
  // it is exactly the product. b_q holds only the row_b bits not yet consumed.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : gen_stg
    logic [SEG-1:0]   a_seg;
    logic [SEG-1:0]   b_seg;
    logic             c_in;
    logic [SEG:0]     sum;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] x_q;
    logic             c_q;
    logic             en;

    assign en = ld[k] & src_vld[k];

    if (k == 0) begin : g_src
      assign a_seg = row_a[SEG-1:0];
      assign b_seg = row_b[SEG-1:0];
      assign c_in  = cin;
      if (STAGES == 1) begin : g_one
        assign x_d = sum[SEG-1:0];
      end else begin : g_many
        assign x_d = {sum[SEG-1:0], row_a[WIDTH-1:SEG]};
      end
    end else begin : g_src
      assign a_seg = gen_stg[k-1].x_q[SEG-1:0];
      assign b_seg = gen_stg[k-1].g_b.b_q[SEG-1:0];
      assign c_in  = gen_stg[k-1].c_q;
      assign x_d   = {sum[SEG-1:0], gen_stg[k-1].x_q[WIDTH-1:SEG]};
    end

    assign sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        x_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        x_q <= x_d;
        c_q <= sum[SEG];
      end
    end

    // The last stage consumes the final row_b segment, so it keeps none.
    if (k < STAGES - 1) begin : g_b
      logic [WIDTH-(k+1)*SEG-1:0] b_d;
      logic [WIDTH-(k+1)*SEG-1:0] b_q;
      if (k == 0) begin : g_first
        assign b_d = row_b[WIDTH-1:SEG];
      end else begin : g_next
        assign b_d = gen_stg[k-1].g_b.b_q[WIDTH-k*SEG-1:SEG];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          b_q <= '0;
        end else if (en) begin
          b_q <= b_d;
        end
      end
    end

`ifdef DADDA_FINAL_CPA_ZERO_FLAG_EN
    // Running AND of per-segment zero terms; the last stage also folds in cout.
    logic z_in;
    logic z_d;
    logic z_q;
    if (k == 0) begin : g_zin_first
      assign z_in = 1'b1;
    end else begin : g_zin_next
      assign z_in = gen_stg[k-1].z_q;
    end
    if (k == STAGES - 1) begin : g_zlast
      assign z_d = z_in & (sum[SEG-1:0] == '0) & ~sum[SEG];
    end else begin : g_zmid
      assign z_d = z_in & (sum[SEG-1:0] == '0);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        z_q <= 1'b0;
      end else if (en) begin
        z_q <= z_d;
      end
    end
`endif
  end

  assign prod = gen_stg[STAGES-1].x_q;
  assign cout = gen_stg[STAGES-1].c_q;
`ifdef DADDA_FINAL_CPA_ZERO_FLAG_EN
  assign prod_zero = gen_stg[STAGES-1].z_q;
`endif

endmodule

// File: doc/dadda_final_cpa.md
Name: dadda_final_cpa

Overview:
- Final carry-propagate stage of the Dadda multiplier. It sits directly downstream of the full-adder reduction tree.
- Accepts the two reduced rows (sum row, carry row) left after reduction to height 2 and adds them into the final product.
- Implemented as a segmented, pipelined ripple adder with valid/ready handshakes on both sides, so the tree can feed it back-to-back and the consumer can apply backpressure.

Parameters:
- WIDTH, 16, bit width of each input row and of the result (2N for an NxN multiplier).
- SEG, 4, bits added per pipeline stage; WIDTH must be a multiple of SEG (elaboration error otherwise).
- STAGES, WIDTH/SEG, derived number of pipeline stages; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  row_a/row_b/cin valid this cycle.
- in_ready  output  1  stage 0 can accept a transfer.
- row_a  input  WIDTH  reduced sum row from the tree.
- row_b  input  WIDTH  reduced carry row from the tree (already bit-aligned).
- cin  input  1  carry into bit 0.
- out_valid  output  1  prod/cout valid.
- out_ready  input  1  consumer accepts prod.
- prod  output  WIDTH  row_a + row_b + cin, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Per-stage registers: valid bit; remaining upper operand bits; accumulated low result bits; carry.
- Stage k adds bits [k*SEG +: SEG] of both operands plus the incoming carry, appends the SEG sum bits, and passes the carry on.
- Stage 0 performs segment 0 combinationally from the inputs before registering.
- Stall rule: stage k loads when stage k is empty or stage k advances this cycle. Stage k advances when stage k+1 loads, or, for the last stage, on an output transfer.
  - in_ready = stage0 empty OR stage0 advances (combinational from out_ready through the chain; no bubble insertion).
  - A bubble in any stage is collapsed by the upstream stage while downstream is stalled.
- Latency: STAGES cycles from input transfer to out_valid when unstalled. Default: 4 cycles.
- Throughput: one result per cycle when out_ready is held high.
- Outputs:
  - out_valid = last stage valid.
  - prod and cout are direct register outputs of the last stage.
  - prod and cout hold stable while out_valid && !out_ready.
- Reset: all stage valid bits 0 and all data registers 0. Consequently out_valid=0, prod=0, cout=0, and in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight results are discarded, none emerge. An input presented in the reset cycle is not captured.
- Simultaneous input and output transfer while full: both occur, and occupancy is unchanged.
- Arithmetic: unsigned, modulo 2^WIDTH on prod, with the carry reported on cout. Example: all-ones + 1 gives prod=0, cout=1.
- Inputs are sampled only on a transfer; row_a/row_b may change freely when in_valid=0.
- No combinational path from row_a/row_b/cin to any output.

Optional Feature:
- Macro DADDA_FINAL_CPA_ZERO_FLAG_EN.
- When defined:
  - adds output port prod_zero (1 bit), valid with out_valid;
  - prod_zero=1 iff prod==0 AND cout==0;
  - computed one segment per stage (running AND of segment-zero terms carried in the pipeline), so no extra latency;
  - reset value 0;
  - held while stalled.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then a single add, row_a=16'h00FF, row_b=16'h0001, cin=0, out_ready=1 -> out_valid on cycle 4 after transfer, prod=16'h0100, cout=0; in_ready=1 throughout.
- Wrap: row_a=16'hFFFF, row_b=16'h0000, cin=1 -> prod=16'h0000, cout=1 (prod_zero=0 when the macro is enabled); row_a=0, row_b=0, cin=0 -> prod=0, cout=0, prod_zero=1.
- Streaming, 8 back-to-back inputs with random rows and out_ready=1 -> 8 outputs on consecutive cycles, in order, each equal to row_a+row_b+cin.
- Backpressure, out_ready=0 while 6 inputs are offered -> exactly 4 accepted, then in_ready=0. Raise out_ready -> 4 results in order with no loss or duplication, and the remaining 2 accepted as slots free. prod stable during the stall.
- Bubble collapse, inputs on cycles 0 and 2 with out_ready=0 until cycle 10 -> both results held adjacent in the last two stages; released on consecutive cycles once out_ready=1.
- Reset mid-flight, 3 inputs accepted then rst high for 1 cycle -> out_valid stays 0 with no stale results. Next input after reset produces the correct result at latency 4.
